// File: rtl/rom_ctrl_pkg.sv
// Shared types and helpers for the ROM controller check sequencer.
// Sparse state encodings keep a pairwise Hamming distance of at least 3.
package rom_ctrl_pkg;

  localparam int StateW = 6;

  typedef enum logic [StateW-1:0] {
    StIdle     = 6'b000111,
    StReadExp  = 6'b011001,
    StWaitRd   = 6'b101010,
    StWaitHash = 6'b110100,
    StCompare  = 6'b111111,
    StWaitCmp  = 6'b100001,
    StDone     = 6'b010010
  } rom_check_seq_state_e;

  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  function automatic int exp_digest_base(
    input int rom_depth,
    input int num_words
  );
    return rom_depth - num_words;
  endfunction

endpackage

// File: rtl/prim_count.sv
// Redundant up-counter: a true copy plus an inverted copy.
// Any disagreement between the two copies raises err_o.
module prim_count #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             incr_en_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] cnt_n_q, cnt_n_d;

  always_comb begin
    cnt_d   = cnt_q;
    cnt_n_d = cnt_n_q;
    if (clr_i) begin
      cnt_d   = '0;
      cnt_n_d = '1;
    end else if (incr_en_i) begin
      cnt_d   = cnt_q + 1'b1;
      cnt_n_d = cnt_n_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      cnt_n_q <= '1;
    end else begin
      cnt_q   <= cnt_d;
      cnt_n_q <= cnt_n_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = (cnt_q != ~cnt_n_q);

endmodule

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparsely encoded FSMs.
// Kept as its own instance so the raw encoding is a single named flop.
module prim_sparse_fsm_flop #(
  parameter int               Width      = 6,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rom_ctrl_check_seq.sv
// ROM integrity check sequencer: fetch expected digest, capture hash,
// kick the comparator and publish the verdict to pwrmgr/keymgr.
module rom_ctrl_check_seq
  import rom_ctrl_pkg::*;
#(
  parameter  int NumWords = 8,
  parameter  int RomDepth = 8192,
  localparam int RomAw    = $clog2(RomDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  rom_req_o,
  output logic [RomAw-1:0]      rom_addr_o,
  input  logic                  rom_rvalid_i,
  input  logic [31:0]           rom_rdata_i,
  input  logic                  hash_valid_i,
  input  logic [NumWords*32-1:0] hash_digest_i,
  output logic                  cmp_start_o,
  input  logic                  cmp_done_i,
  input  logic [3:0]            cmp_good_i,
  output logic [NumWords*32-1:0] digest_o,
  output logic [NumWords*32-1:0] exp_digest_o,
  output logic                  keymgr_valid_o,
  output logic [3:0]            pwrmgr_done_o,
  output logic [3:0]            pwrmgr_good_o,
  output logic                  alert_o
);

  localparam int IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [RomAw-1:0] BaseAddr =
    RomAw'(exp_digest_base(RomDepth, NumWords));
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  rom_check_seq_state_e state_q, state_d;
  logic [StateW-1:0]    state_raw;

  logic                  illegal;
  logic                  cnt_clr, cnt_incr, cnt_err;
  logic [IdxW-1:0]       idx;
  logic                  exp_we;
  logic                  pre_cmp, cmp_ok_st;
  logic                  hash_accept, alert_evt;

  logic                  rom_req_q, cmp_start_q, kmv_q, alert_q;
  logic                  hash_seen_q;
  mubi4_t                done_q, good_q;
  logic [NumWords*32-1:0] digest_q, exp_q;

  prim_sparse_fsm_flop #(
    .Width      (StateW),
    .ResetValue (StIdle)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_raw)
  );

  assign state_q = rom_check_seq_state_e'(state_raw);

  prim_count #(
    .Width (IdxW)
  ) u_idx_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (cnt_clr),
    .incr_en_i (cnt_incr),
    .cnt_o     (idx),
    .err_o     (cnt_err)
  );

  always_comb begin
    state_d  = state_q;
    illegal  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_incr = 1'b0;
    exp_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        state_d = StReadExp;
      end
      StReadExp: state_d = StWaitRd;
      StWaitRd: begin
        if (rom_rvalid_i) begin
          exp_we = 1'b1;
          if (idx == LastIdx) begin
            state_d = StWaitHash;
          end else begin
            cnt_incr = 1'b1;
            state_d  = StReadExp;
          end
        end
      end
      StWaitHash: begin
        if (hash_seen_q) state_d = StCompare;
      end
      StCompare: state_d = StWaitCmp;
      StWaitCmp: begin
        if (cmp_done_i) state_d = StDone;
      end
      StDone: state_d = StDone;
      default: illegal = 1'b1;
    endcase
  end

  assign pre_cmp = (state_q == StIdle) || (state_q == StReadExp) ||
                   (state_q == StWaitRd) || (state_q == StWaitHash);
  assign cmp_ok_st = (state_q == StWaitCmp) || (state_q == StDone);
  assign hash_accept = hash_valid_i && pre_cmp && !hash_seen_q;

  assign alert_evt = illegal || cnt_err ||
                     (rom_rvalid_i && (state_q != StWaitRd)) ||
                     (cmp_done_i && !cmp_ok_st) ||
                     (hash_valid_i && (!pre_cmp || hash_seen_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rom_req_q   <= 1'b0;
      cmp_start_q <= 1'b0;
      kmv_q       <= 1'b0;
      alert_q     <= 1'b0;
      hash_seen_q <= 1'b0;
      done_q      <= MuBi4False;
      good_q      <= MuBi4False;
      digest_q    <= '0;
      exp_q       <= '0;
    end else begin
      rom_req_q   <= (state_d == StReadExp);
      cmp_start_q <= (state_d == StCompare);
      alert_q     <= alert_q | alert_evt;
      if (hash_accept) begin
        digest_q    <= hash_digest_i;
        hash_seen_q <= 1'b1;
      end
      if (exp_we) begin
        for (int i = 0; i < NumWords; i++) begin
          if (idx == IdxW'(i)) exp_q[i*32 +: 32] <= rom_rdata_i;
        end
      end
      if (state_q == StWaitCmp && cmp_done_i) begin
        done_q <= MuBi4True;
        good_q <= cmp_good_i;
        kmv_q  <= 1'b1;
      end
      // A corrupted state must never advertise a finished check.
      if (illegal) begin
        done_q <= MuBi4False;
        good_q <= MuBi4False;
        kmv_q  <= 1'b0;
      end
    end
  end

  assign rom_req_o      = rom_req_q;
  assign rom_addr_o     = BaseAddr + RomAw'(idx);
  assign cmp_start_o    = cmp_start_q;
  assign digest_o       = digest_q;
  assign exp_digest_o   = exp_q;
  assign keymgr_valid_o = kmv_q;
  assign pwrmgr_done_o  = done_q;
  assign pwrmgr_good_o  = good_q;
  assign alert_o        = alert_q;

endmodule
